// File: rtl/sha1_stream_core.sv
// SHA-1 engine chaining pre-padded 512-bit blocks into one 160-bit digest, R rounds per clock.
// Accept-to-digest_valid 80/R+2 cycles; blk_ready only in IDLE, digest held until digest_ready.
module sha1_stream_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [159:0] digest,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DIGEST} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } words_t;

    localparam words_t IV = '{a: 32'h67452301, b: 32'hEFCDAB89, c: 32'h98BADCFE,
                              d: 32'h10325476, e: 32'hC3D2E1F0};
    localparam logic [6:0] RPC = 7'(ROUNDS_PER_CYCLE);

    state_t      state;
    words_t      h;
    words_t      v;
    words_t      v_nxt;
    words_t      h_sum;
    logic [31:0] w_buf [16];
    logic [31:0] w_nxt [16];
    logic [6:0]  t;
    logic        last_q;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rotl30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    // Unrolled rounds; later rounds in the same cycle see schedule words written by earlier ones.
    always_comb begin : round_logic
        logic [6:0]  tt;
        logic [3:0]  s;
        logic [31:0] wt;
        logic [31:0] f;
        logic [31:0] k;
        logic [31:0] temp;
        tt    = '0;
        s     = '0;
        wt    = '0;
        f     = '0;
        k     = '0;
        temp  = '0;
        v_nxt = v;
        w_nxt = w_buf;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            tt = t + 7'(i);
            s  = tt[3:0];
            if (tt < 7'd16) begin
                wt = w_nxt[s];
            end else begin
                wt = rotl1(w_nxt[s - 4'd3] ^ w_nxt[s - 4'd8] ^ w_nxt[s - 4'd14] ^ w_nxt[s]);
                w_nxt[s] = wt;
            end
            if (tt < 7'd20) begin
                f = (v_nxt.b & v_nxt.c) | (~v_nxt.b & v_nxt.d);
                k = 32'h5A827999;
            end else if (tt < 7'd40) begin
                f = v_nxt.b ^ v_nxt.c ^ v_nxt.d;
                k = 32'h6ED9EBA1;
            end else if (tt < 7'd60) begin
                f = (v_nxt.b & v_nxt.c) | (v_nxt.b & v_nxt.d) | (v_nxt.c & v_nxt.d);
                k = 32'h8F1BBCDC;
            end else begin
                f = v_nxt.b ^ v_nxt.c ^ v_nxt.d;
                k = 32'hCA62C1D6;
            end
            temp  = rotl5(v_nxt.a) + f + v_nxt.e + k + wt;
            v_nxt = '{a: temp, b: v_nxt.a, c: rotl30(v_nxt.b), d: v_nxt.c, e: v_nxt.d};
        end
    end

    assign h_sum = '{a: h.a + v.a, b: h.b + v.b, c: h.c + v.c, d: h.d + v.d, e: h.e + v.e};

    assign blk_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign digest_valid = (state == DIGEST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            h      <= IV;
            v      <= '0;
            t      <= '0;
            last_q <= 1'b0;
            digest <= '0;
            for (int i = 0; i < 16; i++) w_buf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) w_buf[i] <= blk_data[511 - 32*i -: 32];
                        last_q <= blk_last;
                        t      <= '0;
                        if (blk_first) begin
                            v <= IV;
                            h <= IV;
                        end else begin
                            v <= h;
                        end
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    v     <= v_nxt;
                    w_buf <= w_nxt;
                    t     <= t + RPC;
                    if (t + RPC == 7'd80) state <= UPDATE;
                end
                UPDATE: begin
                    h <= h_sum;
                    if (last_q) begin
                        digest <= h_sum;
                        state  <= DIGEST;
                    end else begin
                        state <= IDLE;
                    end
                end
                DIGEST: begin
                    if (digest_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_stream_core.sv
// Bench for sha1_stream_core: known-answer vectors plus random chains against a full-schedule SHA-1 model.
module tb_sha1_stream_core;

    logic         tb_local_clock;
    logic         reset;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic [2:0]   blk_valid;
    logic [2:0]   blk_ready;
    logic [2:0]   digest_valid;
    logic [2:0]   digest_ready;
    logic [2:0]   busy;
    logic [159:0] digest [3];

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [159:0] model_h [3];
    int           rpc_of  [3] = '{1, 4, 20};

    localparam logic [159:0] IV_H     = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;
    localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_T3A  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_T3B  = {480'h0, 32'h000001c0};
    localparam logic [159:0] DG_ABC   = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] DG_EMPTY = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
    localparam logic [159:0] DG_T3    = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

    sha1_stream_core #(.ROUNDS_PER_CYCLE(1)) u_dut_r1 (
        .clk(tb_local_clock), .reset(reset), .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]),
        .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
        .digest_valid(digest_valid[0]), .digest_ready(digest_ready[0]), .digest(digest[0]),
        .busy(busy[0]));

    sha1_stream_core #(.ROUNDS_PER_CYCLE(4)) u_dut_r4 (
        .clk(tb_local_clock), .reset(reset), .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]),
        .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
        .digest_valid(digest_valid[1]), .digest_ready(digest_ready[1]), .digest(digest[1]),
        .busy(busy[1]));

    sha1_stream_core #(.ROUNDS_PER_CYCLE(20)) u_dut_r20 (
        .clk(tb_local_clock), .reset(reset), .blk_valid(blk_valid[2]), .blk_ready(blk_ready[2]),
        .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
        .digest_valid(digest_valid[2]), .digest_ready(digest_ready[2]), .digest(digest[2]),
        .busy(busy[2]));

    initial begin
        tb_local_clock = 1'b0;
        forever #5 tb_local_clock = ~tb_local_clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Straight textbook compression: full 80-word schedule, no circular buffer.
    function automatic logic [159:0] sha1_compress(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, x, tmp;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            x    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = (x << 1) | (x >> 31);
        end
        a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = ((a << 5) | (a >> 27)) + f + e + k + w[i];
            e = d; d = c; c = (b << 30) | (b >> 2); b = a; a = tmp;
        end
        return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    task automatic send_block(input int k, input logic [511:0] d, input logic f, input logic l);
        int guard = 0;
        blk_data     = d;
        blk_first    = f;
        blk_last     = l;
        blk_valid[k] = 1'b1;
        while (!blk_ready[k] && guard < 300) begin
            @(posedge tb_local_clock); #1;
            guard++;
        end
        n_tests++;
        if (blk_ready[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake dut%0d: blk_ready=%b, required 1 within 300 cycles", k, blk_ready[k]);
        end
        @(posedge tb_local_clock); #1;
        blk_valid[k] = 1'b0;
        blk_data     = {16{$urandom()}};
        blk_first    = 1'($urandom());
        blk_last     = 1'($urandom());
        if (f) model_h[k] = IV_H;
        model_h[k] = sha1_compress(model_h[k], d);
    endtask

    task automatic wait_digest(input int k, output int cyc);
        cyc = 0;
        while (!digest_valid[k] && cyc < 300) begin
            @(posedge tb_local_clock); #1;
            cyc++;
        end
        n_tests++;
        if (digest_valid[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL digest_timeout dut%0d: digest_valid=%b after %0d cycles, required 1", k, digest_valid[k], cyc);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        blk_valid    = '0;
        digest_ready = '1;
        blk_data     = '0;
        blk_first    = 1'b0;
        blk_last     = 1'b0;
        repeat (2) @(posedge tb_local_clock);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            model_h[k] = IV_H;
            n_tests++;
            if (blk_ready[k] !== 1'b1) begin n_fail++; $display("FAIL reset_blk_ready dut%0d: got %b want 1", k, blk_ready[k]); end
            n_tests++;
            if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b want 0", k, busy[k]); end
            n_tests++;
            if (digest_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_digest_valid dut%0d: got %b want 0", k, digest_valid[k]); end
            n_tests++;
            if (digest[k] !== 160'h0) begin n_fail++; $display("FAIL reset_digest dut%0d: got %h want 0", k, digest[k]); end
        end
    endtask

    task automatic test_single(input int k, input logic [511:0] blk, input logic [159:0] exp_dg);
        int cyc;
        send_block(k, blk, 1'b1, 1'b1);
        wait_digest(k, cyc);
        n_tests++;
        if (cyc + 1 !== 80 / rpc_of[k] + 2) begin
            n_fail++;
            $display("FAIL latency dut%0d: got %0d cycles want %0d", k, cyc + 1, 80 / rpc_of[k] + 2);
        end
        n_tests++;
        if (digest[k] !== exp_dg) begin n_fail++; $display("FAIL single_digest dut%0d: got %h want %h", k, digest[k], exp_dg); end
        @(posedge tb_local_clock); #1;
        n_tests++;
        if (digest_valid[k] !== 1'b0 || blk_ready[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL digest_consume dut%0d: valid=%b ready=%b want 0/1", k, digest_valid[k], blk_ready[k]);
        end
    endtask

    task automatic test_two_block(input int k);
        int cyc = 0;
        int dcyc;
        logic saw_dv = 1'b0;
        send_block(k, BLK_T3A, 1'b1, 1'b0);
        n_tests++;
        if (blk_ready[k] !== 1'b0 || busy[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL two_block_busy dut%0d: ready=%b busy=%b want 0/1", k, blk_ready[k], busy[k]);
        end
        while (!blk_ready[k] && cyc < 300) begin
            if (digest_valid[k]) saw_dv = 1'b1;
            @(posedge tb_local_clock); #1;
            cyc++;
        end
        n_tests++;
        if (cyc !== 80 / rpc_of[k] + 1) begin
            n_fail++;
            $display("FAIL block_period dut%0d: got %0d want %0d", k, cyc + 1, 80 / rpc_of[k] + 2);
        end
        n_tests++;
        if (saw_dv !== 1'b0 || digest_valid[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL early_digest dut%0d: digest_valid seen=%b want 0", k, saw_dv);
        end
        send_block(k, BLK_T3B, 1'b0, 1'b1);
        wait_digest(k, dcyc);
        n_tests++;
        if (digest[k] !== DG_T3) begin n_fail++; $display("FAIL two_block_digest dut%0d: got %h want %h", k, digest[k], DG_T3); end
        @(posedge tb_local_clock); #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        digest_ready[0] = 1'b0;
        send_block(0, BLK_ABC, 1'b1, 1'b1);
        wait_digest(0, cyc);
        for (int i = 0; i < 20; i++) begin
            blk_valid[0] = 1'b1;
            blk_data     = {16{$urandom()}};
            blk_first    = 1'b1;
            blk_last     = 1'b1;
            @(posedge tb_local_clock); #1;
            n_tests++;
            if (digest_valid[0] !== 1'b1 || blk_ready[0] !== 1'b0 || digest[0] !== DG_ABC) begin
                n_fail++;
                $display("FAIL hold_digest cycle %0d: valid=%b ready=%b digest=%h want 1/0/%h",
                         i, digest_valid[0], blk_ready[0], digest[0], DG_ABC);
            end
        end
        blk_valid[0]    = 1'b0;
        digest_ready[0] = 1'b1;
        @(posedge tb_local_clock); #1;
        n_tests++;
        if (digest_valid[0] !== 1'b0 || digest[0] !== DG_ABC) begin
            n_fail++;
            $display("FAIL digest_retained: valid=%b digest=%h want 0/%h", digest_valid[0], digest[0], DG_ABC);
        end
        send_block(0, BLK_EMPTY, 1'b1, 1'b1);
        wait_digest(0, cyc);
        n_tests++;
        if (digest[0] !== DG_EMPTY) begin n_fail++; $display("FAIL after_backpressure: got %h want %h", digest[0], DG_EMPTY); end
        @(posedge tb_local_clock); #1;
    endtask

    task automatic test_reset_mid_round();
        int cyc = 0;
        send_block(0, BLK_T3A, 1'b1, 1'b0);
        while (!blk_ready[0] && cyc < 300) begin @(posedge tb_local_clock); #1; cyc++; end
        send_block(0, BLK_T3B, 1'b0, 1'b1);
        repeat (30) @(posedge tb_local_clock);
        #1;
        n_tests++;
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy[0]); end
        reset = 1'b1;
        @(posedge tb_local_clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) model_h[k] = IV_H;
        n_tests++;
        if (blk_ready[0] !== 1'b1 || busy[0] !== 1'b0 || digest_valid[0] !== 1'b0 || digest[0] !== 160'h0) begin
            n_fail++;
            $display("FAIL mid_reset_state: ready=%b busy=%b valid=%b digest=%h want 1/0/0/0",
                     blk_ready[0], busy[0], digest_valid[0], digest[0]);
        end
        send_block(0, BLK_ABC, 1'b0, 1'b1);
        wait_digest(0, cyc);
        n_tests++;
        if (digest[0] !== DG_ABC) begin n_fail++; $display("FAIL restart_from_iv: got %h want %h", digest[0], DG_ABC); end
        @(posedge tb_local_clock); #1;
    endtask

    task automatic test_random_chains(input int k, input int n_msgs);
        logic [511:0] d;
        int           nblk, cyc;
        logic         f;
        for (int m = 0; m < n_msgs; m++) begin
            nblk = $urandom_range(1, 3);
            for (int b = 0; b < nblk; b++) begin
                for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom();
                f = (b == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
                digest_ready[k] = 1'($urandom());
                send_block(k, d, f, b == nblk - 1);
                // Stray valids while busy must be ignored.
                for (int g = $urandom_range(0, 3); g > 0; g--) begin
                    blk_valid[k] = 1'b1;
                    blk_data     = {16{$urandom()}};
                    @(posedge tb_local_clock); #1;
                end
                blk_valid[k] = 1'b0;
                if (b == nblk - 1) begin
                    wait_digest(k, cyc);
                    n_tests++;
                    if (digest[k] !== model_h[k]) begin
                        n_fail++;
                        $display("FAIL random_digest dut%0d msg %0d: got %h want %h", k, m, digest[k], model_h[k]);
                    end
                    repeat ($urandom_range(0, 3)) @(posedge tb_local_clock);
                    #1;
                    digest_ready[k] = 1'b1;
                    @(posedge tb_local_clock); #1;
                end else begin
                    cyc = 0;
                    while (!blk_ready[k] && cyc < 300) begin @(posedge tb_local_clock); #1; cyc++; end
                end
            end
        end
        digest_ready[k] = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single(0, BLK_ABC, DG_ABC);
        test_single(0, BLK_EMPTY, DG_EMPTY);
        test_two_block(0);
        test_backpressure();
        test_reset_mid_round();
        test_random_chains(0, 8);
        for (int k = 1; k < 3; k++) begin
            test_single(k, BLK_ABC, DG_ABC);
            test_single(k, BLK_EMPTY, DG_EMPTY);
            test_two_block(k);
            test_random_chains(k, 6);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
